life_row_engine: RTL and testbench

- Streaming next-generation engine for a Game of Life grid of ROWS x WIDTH cells.
- Accepts one full grid row per input handshake and emits the corresponding next-generation row through a valid/ready output port.
- Generalises the single-cell "exactly three live neighbours" decode into:
  - a WIDTH-cell row of neighbour counters;
  - a parametrised birth/survive rule;
  - a two-row line buffer with flow control.
- Sits between the grid state memory and the display/frame writer.

---
 rtl/life_row_engine.sv | 115 +++++++++++
 tb/tb_life_row_engine.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/life_row_engine.sv
// life_row_engine: streaming Game of Life engine, one row in and one next-generation row out per handshake.
// Define LIFE_HWRAP_EN for horizontal toroidal wrap; by default all four grid edges read as dead.
module life_row_engine #(
  parameter int WIDTH = 16,
  parameter int ROWS = 16,
  parameter logic [8:0] BIRTH_MASK = 9'b000001000,
  parameter logic [8:0] SURVIVE_MASK = 9'b000001100
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_row,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_row,
  output logic             out_last,
  output logic [15:0]      gen_count
);
  localparam int CW = $clog2(ROWS);
  localparam logic [15:0] BM = {7'b0, BIRTH_MASK};
  localparam logic [15:0] SM = {7'b0, SURVIVE_MASK};
  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_e;
  state_e state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d, cur_q, cur_d, row_q, row_d, below, nxt;
  logic [WIDTH+1:0] a_e, m_e, b_e;
  logic [CW-1:0] cnt_q, cnt_d;
  logic valid_q, valid_d, last_q, last_d, can_load, acc;
  logic [15:0] gen_q, gen_d;
  logic [3:0] n;
  // The row below the last grid row is dead, so FLUSH feeds zeros.
  assign below = (state_q == FLUSH) ? '0 : in_row;
  // Extended rows: bit 0 is column -1, bit WIDTH+1 is column WIDTH.
`ifdef LIFE_HWRAP_EN
  assign a_e = {prev_q[0], prev_q, prev_q[WIDTH-1]};
  assign m_e = {cur_q[0], cur_q, cur_q[WIDTH-1]};
  assign b_e = {below[0], below, below[WIDTH-1]};
`else
  assign a_e = {1'b0, prev_q, 1'b0};
  assign m_e = {1'b0, cur_q, 1'b0};
  assign b_e = {1'b0, below, 1'b0};
`endif
  always_comb begin
    nxt = '0;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = 4'(a_e[i]) + 4'(a_e[i+1]) + 4'(a_e[i+2]) + 4'(m_e[i]) + 4'(m_e[i+2])
        + 4'(b_e[i]) + 4'(b_e[i+1]) + 4'(b_e[i+2]);
      nxt[i] = cur_q[i] ? SM[n] : BM[n];
    end
  end
  always_comb begin
    can_load = !valid_q | out_ready;
    in_ready = (state_q == FILL) | ((state_q == RUN) & can_load);
    acc = in_valid & in_ready;
    state_d = state_q;
    prev_d = prev_q;
    cur_d = cur_q;
    cnt_d = cnt_q;
    row_d = row_q;
    last_d = last_q;
    valid_d = valid_q & !out_ready;
    gen_d = gen_q + 16'(valid_q & out_ready & last_q);
    case (state_q)
      FILL: if (acc) begin
        cur_d = in_row;
        prev_d = '0;
        cnt_d = CW'(1);
        state_d = RUN;
      end
      RUN: if (acc) begin
        row_d = nxt;
        last_d = 1'b0;
        valid_d = 1'b1;
        prev_d = cur_q;
        cur_d = in_row;
        cnt_d = cnt_q + CW'(1);
        state_d = (cnt_q == CW'(ROWS - 1)) ? FLUSH : RUN;
      end
      FLUSH: if (can_load) begin
        row_d = nxt;
        last_d = 1'b1;
        valid_d = 1'b1;
        cnt_d = '0;
        state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FILL;
      prev_q <= '0;
      cur_q <= '0;
      cnt_q <= '0;
      row_q <= '0;
      last_q <= 1'b0;
      valid_q <= 1'b0;
      gen_q <= '0;
    end else begin
      state_q <= state_d;
      prev_q <= prev_d;
      cur_q <= cur_d;
      cnt_q <= cnt_d;
      row_q <= row_d;
      last_q <= last_d;
      valid_q <= valid_d;
      gen_q <= gen_d;
    end
  end
  assign out_valid = valid_q;
  assign out_row = row_q;
  assign out_last = last_q;
  assign gen_count = gen_q;
endmodule

// File: tb/tb_life_row_engine.sv
// tb_life_row_engine: directed checks of a Conway (B3/S23) and a Seeds (B2/S) engine, both 5x5, sharing stimulus.
module tb_life_row_engine;
  logic clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [4:0] in_row = '0;
  logic in_ready, out_valid, out_last, s_in_ready, s_out_valid, s_out_last;
  logic [4:0] out_row, s_out_row;
  logic [15:0] gen_count, s_gen_count;
  logic [5:0] q[$];
  logic [5:0] sq[$];
  int tests = 0, fails = 0;
`ifdef LIFE_HWRAP_EN
  localparam logic [4:0] EDGE_R2 = 5'b10011;
`else
  localparam logic [4:0] EDGE_R2 = 5'b00011;
`endif
  always #5 clk = ~clk;

  life_row_engine #(.WIDTH(5), .ROWS(5)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_last(out_last),
    .gen_count(gen_count)
  );
  life_row_engine #(.WIDTH(5), .ROWS(5), .BIRTH_MASK(9'b000000100), .SURVIVE_MASK(9'b0)) u_seeds (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(s_in_ready), .in_row(in_row),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_row(s_out_row), .out_last(s_out_last),
    .gen_count(s_gen_count)
  );

  // Record every completed output handshake in order.
  always @(posedge clk) begin
    if (out_valid && out_ready) q.push_back({out_last, out_row});
    if (s_out_valid && out_ready) sq.push_back({s_out_last, s_out_row});
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic feed(input logic [4:0] r);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_row = r;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_wait", 16'(t < 50), 16'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run_gen(input logic [4:0] r0, r1, r2, r3, r4);
    feed(r0); feed(r1); feed(r2); feed(r3); feed(r4);
    drain();
  endtask

  task automatic pop_check(input string tag, input bit s, input logic [4:0] er, input logic el);
    logic [5:0] e;
    e = 6'h3f;
    check({tag, "_avail"}, 16'(s ? sq.size() > 0 : q.size() > 0), 16'd1);
    if (s && sq.size() > 0) e = sq.pop_front();
    else if (!s && q.size() > 0) e = q.pop_front();
    check({tag, "_row"}, 16'(e[4:0]), 16'(er));
    check({tag, "_last"}, 16'(e[5]), 16'(el));
  endtask

  task automatic expect5(input string tag, input bit s, input logic [4:0] e0, e1, e2, e3, e4);
    pop_check({tag, "0"}, s, e0, 1'b0);
    pop_check({tag, "1"}, s, e1, 1'b0);
    pop_check({tag, "2"}, s, e2, 1'b0);
    pop_check({tag, "3"}, s, e3, 1'b0);
    pop_check({tag, "4"}, s, e4, 1'b1);
    check({tag, "_extra"}, 16'(s ? sq.size() : q.size()), 16'd0);
  endtask

  initial begin
    #12;
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_out_row", 16'(out_row), 16'd0);
    check("rst_out_last", 16'(out_last), 16'd0);
    check("rst_gen", gen_count, 16'd0);
    check("rst_in_ready", 16'(in_ready), 16'd1);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    // Blinker
    run_gen(5'b00000, 5'b00100, 5'b00100, 5'b00100, 5'b00000);
    expect5("blink", 1'b0, 5'b00000, 5'b00000, 5'b01110, 5'b00000, 5'b00000);
    check("blink_gen", gen_count, 16'd1);
    // Still-life block, three generations back to back
    for (int g = 0; g < 3; g++) begin
      run_gen(5'b00000, 5'b00110, 5'b00110, 5'b00000, 5'b00000);
      expect5("block", 1'b0, 5'b00000, 5'b00110, 5'b00110, 5'b00000, 5'b00000);
    end
    check("block_gen", gen_count, 16'd4);
    // Vertical blinker on column 0
    run_gen(5'b00000, 5'b00001, 5'b00001, 5'b00001, 5'b00000);
    expect5("edge", 1'b0, 5'b00000, 5'b00000, EDGE_R2, 5'b00000, 5'b00000);
    check("edge_gen", gen_count, 16'd5);
    // Backpressure with output row 2 held in the output register
    feed(5'b00000); feed(5'b00100); feed(5'b00100); feed(5'b00100);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_row = 5'b00000;
    repeat (4) begin
      @(negedge clk);
      check("bp_in_ready", 16'(in_ready), 16'd0);
      check("bp_out_valid", 16'(out_valid), 16'd1);
      check("bp_out_row", 16'(out_row), 16'(5'b01110));
      check("bp_out_last", 16'(out_last), 16'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    feed(5'b00000);
    drain();
    expect5("bp", 1'b0, 5'b00000, 5'b00000, 5'b01110, 5'b00000, 5'b00000);
    check("bp_gen", gen_count, 16'd6);
    // Seeds rule on the second engine, Conway on the first
    sq.delete();
    run_gen(5'b00000, 5'b00000, 5'b00110, 5'b00000, 5'b00000);
    expect5("seeds", 1'b1, 5'b00000, 5'b00110, 5'b00000, 5'b00110, 5'b00000);
    expect5("pair", 1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    check("seeds_gen", s_gen_count, 16'd7);
    check("pair_gen", gen_count, 16'd7);
    // Asynchronous reset mid-generation
    feed(5'b00000); feed(5'b00100); feed(5'b00100);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 16'(out_valid), 16'd0);
    check("mid_rst_gen", gen_count, 16'd0);
    check("mid_rst_s_gen", s_gen_count, 16'd0);
    check("mid_rst_out_row", 16'(out_row), 16'd0);
    check("mid_rst_in_ready", 16'(in_ready), 16'd1);
    @(negedge clk);
    reset_n = 1'b1;
    q.delete();
    sq.delete();
    @(posedge clk);
    #1;
    run_gen(5'b00000, 5'b00100, 5'b00100, 5'b00100, 5'b00000);
    expect5("post_rst", 1'b0, 5'b00000, 5'b00000, 5'b01110, 5'b00000, 5'b00000);
    check("post_rst_gen", gen_count, 16'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
